shift_reg_seq: RTL and testbench

Parametrised sequential shift engine. It is the next generation of the datapath load/shift register: WIDTH-bit storage, parallel load, and single-step serial shifting, plus multi-position shift commands in five modes. A Start command is executed one bit per clock under a down-counter, and a Busy/Done handshake reports progress to the controlling FSM. Sits between the register-file/switch inputs and the ALU result path.

---
 rtl/shift_reg_seq.sv | 134 +++++++++++++
 tb/tb_shift_reg_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq.sv
// Sequential shift engine: parallel load, single-step shift and
// multi-step Start commands tracked by a down-counter with Busy/Done.
module shift_reg_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic [AMT_W-1:0] Amount,
    input  logic [2:0]       Mode,
    input  logic             ShiftIn,
    input  logic             Shift_En,
    output logic [WIDTH-1:0] Data_Out,
    output logic             ShiftOut,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;

    // Returns {shifted-out bit, next data}; reserved modes hold both.
    function automatic logic [WIDTH:0] step_f(
        input logic [WIDTH-1:0] q,
        input logic [2:0]       m,
        input logic             si,
        input logic             so
    );
        logic [WIDTH:0] r;
        r = {so, q};
        case (m)
            MODE_LSL: r = {q[WIDTH-1], q[WIDTH-2:0], si};
            MODE_LSR: r = {q[0], si, q[WIDTH-1:1]};
            MODE_ASR: r = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
            MODE_ROL: r = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR: r = {q[0], q[0], q[WIDTH-1:1]};
            default:  r = {so, q};
        endcase
        return r;
    endfunction

    logic [WIDTH:0] live_step;
    logic [WIDTH:0] latched_step;

    always_comb begin
        live_step    = step_f(data_q, Mode, ShiftIn, sout_q);
        latched_step = step_f(data_q, mode_q, ShiftIn, sout_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        sout_d  = sout_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mode_d = Mode;
                    if (Amount == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                        cnt_d   = Amount;
                    end
                end else if (Shift_En) begin
                    {sout_d, data_d} = live_step;
                end
            end
            S_SHIFT: begin
                {sout_d, data_d} = latched_step;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Load overrides everything and silently aborts a running shift.
        if (Load) begin
            data_d  = D;
            state_d = S_IDLE;
            cnt_d   = '0;
            sout_d  = sout_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
        end
    end

    assign Data_Out = data_q;
    assign ShiftOut = sout_q;
    assign Busy     = (state_q == S_SHIFT);
    assign Done     = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: directed Start/Load/Shift_En vectors with a
// queue of expected {ShiftOut, Data_Out} results checked on each Done.
module tb_shift_reg_seq;

    localparam int WIDTH = 32;
    localparam int AMT_W = 6;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Load;
    logic [WIDTH-1:0] D;
    logic             Start;
    logic [AMT_W-1:0] Amount;
    logic [2:0]       Mode;
    logic             ShiftIn;
    logic             Shift_En;
    logic [WIDTH-1:0] Data_Out;
    logic             ShiftOut;
    logic             Busy;
    logic             Done;

    int tests  = 0;
    int failed = 0;

    logic [WIDTH:0] exp_q[$];

    shift_reg_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (Load),
        .D        (D),
        .Start    (Start),
        .Amount   (Amount),
        .Mode     (Mode),
        .ShiftIn  (ShiftIn),
        .Shift_En (Shift_En),
        .Data_Out (Data_Out),
        .ShiftOut (ShiftOut),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        logic [WIDTH:0] e;
        if (!Reset && Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(Done), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("done_data", 64'(Data_Out), 64'(e[WIDTH-1:0]));
                check("done_sout", 64'(ShiftOut), 64'(e[WIDTH]));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        Load = 1'b1;
        D    = v;
        tick();
        Load = 1'b0;
        check("load", 64'(Data_Out), 64'(v));
    endtask

    // pulse_at >= 0 re-asserts Start on that Busy cycle; it must be ignored.
    task automatic run_op(input string name, input logic [2:0] m,
                          input int amt, input logic si,
                          input logic [WIDTH-1:0] ed, input logic eo,
                          input int pulse_at);
        int busy_n;
        int waited;
        exp_q.push_back({eo, ed});
        Mode    = m;
        Amount  = AMT_W'(amt);
        ShiftIn = si;
        Start   = 1'b1;
        tick();
        Start  = 1'b0;
        busy_n = 0;
        waited = 0;
        while (!Done && waited < 200) begin
            if (Busy) busy_n++;
            Start  = (waited == pulse_at);
            Amount = (waited == pulse_at) ? AMT_W'(7) : AMT_W'(amt);
            tick();
            Start = 1'b0;
            waited++;
        end
        if (waited >= 200) check({name, "_timeout"}, 64'(waited), 64'(0));
        check({name, "_busy_cycles"}, 64'(busy_n), 64'(amt));
        tick();
        check({name, "_done_width"}, 64'(Done), 64'(0));
    endtask

    initial begin
        Reset    = 1'b1;
        Load     = 1'b0;
        D        = '0;
        Start    = 1'b0;
        Amount   = '0;
        Mode     = 3'b000;
        ShiftIn  = 1'b0;
        Shift_En = 1'b0;
        #12;
        check("rst_data", 64'(Data_Out), 64'(0));
        check("rst_flags", 64'({ShiftOut, Busy, Done}), 64'(0));
        Reset = 1'b0;
        tick();

        do_load(32'h8000_0001);
        run_op("lsl4", 3'b000, 4, 1'b1, 32'h0000_001F, 1'b0, -1);

        do_load(32'h8000_0000);
        run_op("asr3", 3'b010, 3, 1'b0, 32'hF000_0000, 1'b0, -1);

        do_load(32'h0000_0001);
        run_op("ror1", 3'b100, 1, 1'b0, 32'h8000_0000, 1'b1, -1);

        run_op("amt0", 3'b000, 0, 1'b1, 32'h8000_0000, 1'b1, -1);

        do_load(32'h0000_0001);
        run_op("rol33", 3'b011, 33, 1'b0, 32'h0000_0002, 1'b0, -1);

        do_load(32'h0000_00A5);
        run_op("rsvd", 3'b101, 3, 1'b1, 32'h0000_00A5, 1'b0, -1);

        do_load(32'h0000_00F8);
        run_op("lsr_midstart", 3'b001, 4, 1'b1, 32'hF000_000F, 1'b1, 1);

        // Load aborts a running LSR on its third Busy cycle.
        do_load(32'hFFFF_FFFF);
        Mode    = 3'b001;
        Amount  = AMT_W'(10);
        ShiftIn = 1'b0;
        Start   = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        check("abort_busy_before", 64'(Busy), 64'(1));
        Load = 1'b1;
        D    = 32'h1234_5678;
        tick();
        Load = 1'b0;
        check("abort_data", 64'(Data_Out), 64'(32'h1234_5678));
        check("abort_busy", 64'(Busy), 64'(0));
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (Done || Busy) seen++;
                tick();
            end
            check("abort_no_done", 64'(seen), 64'(0));
        end

        do_load(32'hC000_0000);
        Mode     = 3'b000;
        ShiftIn  = 1'b0;
        Shift_En = 1'b1;
        tick();
        check("shen1_data", 64'(Data_Out), 64'(32'h8000_0000));
        check("shen1_sout", 64'(ShiftOut), 64'(1));
        tick();
        Shift_En = 1'b0;
        check("shen2_data", 64'(Data_Out), 64'(32'h0000_0000));
        check("shen2_sout", 64'(ShiftOut), 64'(1));
        check("shen_flags", 64'({Busy, Done}), 64'(0));

        Load     = 1'b1;
        Shift_En = 1'b1;
        D        = 32'h55AA_55AA;
        tick();
        Load     = 1'b0;
        Shift_En = 1'b0;
        check("load_over_shen", 64'(Data_Out), 64'(32'h55AA_55AA));

        // Asynchronous reset in the middle of a long shift.
        do_load(32'h0000_00FF);
        Mode    = 3'b000;
        Amount  = AMT_W'(20);
        ShiftIn = 1'b1;
        Start   = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        check("pre_reset_busy", 64'(Busy), 64'(1));
        #2 Reset = 1'b1;
        #1;
        check("async_rst_data", 64'(Data_Out), 64'(0));
        check("async_rst_flags", 64'({ShiftOut, Busy, Done}), 64'(0));
        tick();
        Reset = 1'b0;
        tick();
        tick();
        check("post_rst_idle", 64'({Busy, Done}), 64'(0));
        check("post_rst_data", 64'(Data_Out), 64'(0));

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
